// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_pkg : AHB-Lite encodings and transfer-size helpers                |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HRESP_RETRY   = 2'b10;
  localparam logic [1:0] HRESP_SPLIT   = 2'b11;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // The slave datapath is one word wide, so wider size codes collapse to WORD.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > HSIZE_WORD) ? HSIZE_WORD : size;
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] lo, input logic [2:0] size);
    logic [1:0] res;
    case (clamp_size(size))
      HSIZE_HALF: res = {lo[1], 1'b0};
      HSIZE_WORD: res = 2'b00;
      default:    res = lo;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_cmd_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_cmd_master_if : command, response and AHB-Lite bus signal bundle  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface ahb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [1:0]        htrans;
  logic              hready;
  logic [DATA_W-1:0] hwdata;
  logic              hready_resp;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  hready_resp, hresp, hrdata,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
    output hsel, haddr, hwrite, hsize, hburst, htrans, hready, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output hready_resp, hresp, hrdata,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
    input  hsel, haddr, hwrite, hsize, hburst, htrans, hready, hwdata
  );
endinterface
`default_nettype wire

// File: rtl/ahb_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_cmd_master : valid/ready command to pipelined AHB-Lite SINGLEs    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                hclk,
  input  logic                hreset,
  ahb_cmd_master_if.master    bus
);

  // Address-phase stage
  logic              r_a_valid;
  logic              r_a_write;
  logic [ADDR_W-1:0] r_a_addr;
  logic [2:0]        r_a_size;
  logic [DATA_W-1:0] r_a_wdata;

  // Data-phase stage
  logic              r_d_valid;
  logic              r_d_write;
  logic [DATA_W-1:0] r_d_wdata;

  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic w_adv;
  logic w_err;
  logic w_nonseq;
  logic w_cmd_ready;
  logic w_accept;
  logic w_done;

  // Any non-OKAY response spans two cycles; A stays IDLE across both so it
  // is re-presented cleanly once the failing data phase has retired.
  assign w_adv       = bus.hready_resp;
  assign w_err       = r_d_valid & (bus.hresp != HRESP_OKAY);
  assign w_nonseq    = r_a_valid & ~w_err;
  assign w_cmd_ready = ~hreset & (~r_a_valid | (w_adv & ~w_err));
  assign w_accept    = bus.cmd_valid & w_cmd_ready;
  assign w_done      = r_d_valid & w_adv;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_a_valid <= 1'b0;
      r_a_write <= 1'b0;
      r_a_addr  <= '0;
      r_a_size  <= HSIZE_BYTE;
      r_a_wdata <= '0;
      r_d_valid <= 1'b0;
      r_d_write <= 1'b0;
      r_d_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_a_valid <= 1'b1;
        r_a_write <= bus.cmd_write;
        r_a_addr  <= {bus.cmd_addr[ADDR_W-1:2], align_lo(bus.cmd_addr[1:0], bus.cmd_size)};
        r_a_size  <= clamp_size(bus.cmd_size);
        r_a_wdata <= bus.cmd_wdata;
      end else if (w_adv & w_nonseq) begin
        r_a_valid <= 1'b0;
      end

      if (w_adv) begin
        r_d_valid <= w_nonseq;
        r_d_write <= r_a_write;
        r_d_wdata <= r_a_wdata;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_done;
      r_rsp_write <= w_done & r_d_write;
      r_rsp_rdata <= (w_done & ~r_d_write) ? bus.hrdata : '0;
      r_rsp_err   <= w_done & (bus.hresp != HRESP_OKAY);
    end
  end

  // Outputs are forced quiet for the whole time hreset is high.
  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = ~hreset & r_rsp_valid;
  assign bus.rsp_write = ~hreset & r_rsp_write;
  assign bus.rsp_rdata = hreset ? '0 : r_rsp_rdata;
  assign bus.rsp_err   = ~hreset & r_rsp_err;

  assign bus.hsel   = ~hreset & r_a_valid;
  assign bus.haddr  = hreset ? '0 : r_a_addr;
  assign bus.hwrite = ~hreset & r_a_write;
  assign bus.hsize  = hreset ? HSIZE_BYTE : r_a_size;
  assign bus.hburst = HBURST_SINGLE;
  assign bus.htrans = (~hreset & w_nonseq) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.hready = bus.hready_resp;
  assign bus.hwdata = hreset ? '0 : r_d_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ahb_cmd_master : directed cycle-by-cycle bench for ahb_cmd_master  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_ahb_cmd_master;

  logic hclk;
  logic hreset;
  int   n_checks;
  int   n_errors;

  ahb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_cmd_master #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [31:0] a,
                         input logic [2:0] s, input logic [31:0] d);
    bus.cmd_valid = v;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_size  = s;
    bus.cmd_wdata = d;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    hreset          = 1'b1;
    bus.hready_resp = 1'b1;
    bus.hresp       = 2'b00;
    bus.hrdata      = 32'h0;
    set_cmd(1'b1, 1'b1, 32'h0000_0008, 3'b010, 32'h1111_1111);

    // Reset state, with a command offered that must not be taken
    tick(); tick(); settle();
    check_eq("rst_htrans",    {30'd0, bus.htrans}, 32'd0);
    check_eq("rst_hsel",      {31'd0, bus.hsel}, 32'd0);
    check_eq("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_eq("rst_haddr",     bus.haddr, 32'd0);

    // 1: single write, no wait states
    hreset = 1'b0;
    set_cmd(1'b1, 1'b1, 32'h0000_0004, 3'b010, 32'h0001_23AF);
    settle();
    check_eq("t1_idle_after_rst", {30'd0, bus.htrans}, 32'd0);
    check_eq("t1_cmd_ready",      {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    set_cmd(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    settle();
    check_eq("t1_htrans", {30'd0, bus.htrans}, 32'd2);
    check_eq("t1_hwrite", {31'd0, bus.hwrite}, 32'd1);
    check_eq("t1_haddr",  bus.haddr, 32'h0000_0004);
    check_eq("t1_hsize",  {29'd0, bus.hsize}, 32'd2);
    tick(); settle();
    check_eq("t1_hwdata",     bus.hwdata, 32'h0001_23AF);
    check_eq("t1_htrans_idle", {30'd0, bus.htrans}, 32'd0);
    tick(); settle();
    check_eq("t1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_eq("t1_rsp_write", {31'd0, bus.rsp_write}, 32'd1);
    check_eq("t1_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    check_eq("t1_rsp_rdata", bus.rsp_rdata, 32'd0);
    tick(); settle();
    check_eq("t1_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);

    // 2: write then read of the same word, back to back
    set_cmd(1'b1, 1'b1, 32'h0000_0010, 3'b010, 32'hDEAD_BEEF);
    tick();
    set_cmd(1'b1, 1'b0, 32'h0000_0010, 3'b010, 32'h0);
    settle();
    check_eq("t2_w_htrans",  {30'd0, bus.htrans}, 32'd2);
    check_eq("t2_w_hwrite",  {31'd0, bus.hwrite}, 32'd1);
    check_eq("t2_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    set_cmd(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    settle();
    check_eq("t2_r_htrans", {30'd0, bus.htrans}, 32'd2);
    check_eq("t2_r_hwrite", {31'd0, bus.hwrite}, 32'd0);
    check_eq("t2_r_haddr",  bus.haddr, 32'h0000_0010);
    check_eq("t2_hwdata",   bus.hwdata, 32'hDEAD_BEEF);
    tick();
    bus.hrdata = 32'hDEAD_BEEF;
    settle();
    check_eq("t2_w_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_eq("t2_w_rsp_write", {31'd0, bus.rsp_write}, 32'd1);
    tick();
    bus.hrdata = 32'h0;
    settle();
    check_eq("t2_r_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_eq("t2_r_rsp_write", {31'd0, bus.rsp_write}, 32'd0);
    check_eq("t2_r_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    tick(); settle();
    check_eq("t2_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);

    // 3: two wait states on a read data phase, write 0x44 pending in A
    set_cmd(1'b1, 1'b0, 32'h0000_0040, 3'b010, 32'hA5A5_A5A5);
    tick();
    set_cmd(1'b1, 1'b1, 32'h0000_0044, 3'b010, 32'h0000_0055);
    tick();
    set_cmd(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    for (int i = 0; i < 2; i++) begin
      bus.hready_resp = 1'b0;
      settle();
      check_eq($sformatf("t3_wait%0d_cmd_ready", i), {31'd0, bus.cmd_ready}, 32'd0);
      check_eq($sformatf("t3_wait%0d_haddr", i),     bus.haddr, 32'h0000_0044);
      check_eq($sformatf("t3_wait%0d_htrans", i),    {30'd0, bus.htrans}, 32'd2);
      check_eq($sformatf("t3_wait%0d_hwrite", i),    {31'd0, bus.hwrite}, 32'd1);
      check_eq($sformatf("t3_wait%0d_hwdata", i),    bus.hwdata, 32'hA5A5_A5A5);
      check_eq($sformatf("t3_wait%0d_rsp", i),       {31'd0, bus.rsp_valid}, 32'd0);
      tick();
    end
    bus.hready_resp = 1'b1;
    bus.hrdata      = 32'h1234_5678;
    settle();
    check_eq("t3_last_rsp_none", {31'd0, bus.rsp_valid}, 32'd0);
    check_eq("t3_ready_again",   {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    bus.hrdata = 32'h0;
    settle();
    check_eq("t3_r_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_eq("t3_r_rsp_write", {31'd0, bus.rsp_write}, 32'd0);
    check_eq("t3_r_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    check_eq("t3_w_hwdata",    bus.hwdata, 32'h0000_0055);
    tick(); settle();
    check_eq("t3_w_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_eq("t3_w_rsp_write", {31'd0, bus.rsp_write}, 32'd1);
    tick(); settle();
    check_eq("t3_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);

    // 4: two-cycle ERROR on write 0x1C while write 0x20 waits in A
    set_cmd(1'b1, 1'b1, 32'h0000_001C, 3'b010, 32'h0000_0011);
    tick();
    set_cmd(1'b1, 1'b1, 32'h0000_0020, 3'b010, 32'h0000_0022);
    tick();
    set_cmd(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    bus.hready_resp = 1'b0;
    bus.hresp       = 2'b01;
    settle();
    check_eq("t4_e1_htrans",    {30'd0, bus.htrans}, 32'd0);
    check_eq("t4_e1_hsel",      {31'd0, bus.hsel}, 32'd1);
    check_eq("t4_e1_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    tick();
    bus.hready_resp = 1'b1;
    settle();
    check_eq("t4_e2_htrans",    {30'd0, bus.htrans}, 32'd0);
    check_eq("t4_e2_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    tick();
    bus.hresp = 2'b00;
    settle();
    check_eq("t4_rsp_valid",  {31'd0, bus.rsp_valid}, 32'd1);
    check_eq("t4_rsp_err",    {31'd0, bus.rsp_err}, 32'd1);
    check_eq("t4_rsp_write",  {31'd0, bus.rsp_write}, 32'd1);
    check_eq("t4_reissue",    {30'd0, bus.htrans}, 32'd2);
    check_eq("t4_reissue_ad", bus.haddr, 32'h0000_0020);
    tick(); settle();
    check_eq("t4_hwdata",  bus.hwdata, 32'h0000_0022);
    check_eq("t4_no_rsp",  {31'd0, bus.rsp_valid}, 32'd0);
    tick(); settle();
    check_eq("t4_2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_eq("t4_2_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);

    // 5: size-based alignment and clamping
    set_cmd(1'b1, 1'b0, 32'h0000_0003, 3'b000, 32'h0);
    tick();
    set_cmd(1'b1, 1'b0, 32'h0000_0003, 3'b001, 32'h0);
    settle();
    check_eq("t5_byte_haddr", bus.haddr, 32'h0000_0003);
    check_eq("t5_byte_hsize", {29'd0, bus.hsize}, 32'd0);
    tick();
    set_cmd(1'b1, 1'b1, 32'h0000_0007, 3'b101, 32'h0000_00CC);
    settle();
    check_eq("t5_half_haddr", bus.haddr, 32'h0000_0002);
    check_eq("t5_half_hsize", {29'd0, bus.hsize}, 32'd1);
    tick();
    set_cmd(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    settle();
    check_eq("t5_clamp_hsize", {29'd0, bus.hsize}, 32'd2);
    check_eq("t5_clamp_haddr", bus.haddr, 32'h0000_0004);
    for (int i = 0; i < 4; i++) tick();

    // 6: reset with both stages full
    set_cmd(1'b1, 1'b1, 32'h0000_0030, 3'b010, 32'h0000_0099);
    tick();
    set_cmd(1'b1, 1'b1, 32'h0000_0034, 3'b010, 32'h0000_009A);
    tick();
    set_cmd(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    hreset = 1'b1;
    settle();
    check_eq("t6_in_rst_htrans", {30'd0, bus.htrans}, 32'd0);
    check_eq("t6_in_rst_hsel",   {31'd0, bus.hsel}, 32'd0);
    check_eq("t6_in_rst_ready",  {31'd0, bus.cmd_ready}, 32'd0);
    check_eq("t6_in_rst_hwdata", bus.hwdata, 32'd0);
    tick();
    hreset = 1'b0;
    settle();
    check_eq("t6_post_htrans", {30'd0, bus.htrans}, 32'd0);
    check_eq("t6_post_hsel",   {31'd0, bus.hsel}, 32'd0);
    check_eq("t6_post_rsp",    {31'd0, bus.rsp_valid}, 32'd0);
    set_cmd(1'b1, 1'b1, 32'h0000_0050, 3'b010, 32'h0000_0077);
    settle();
    check_eq("t6_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    set_cmd(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    settle();
    check_eq("t6_htrans", {30'd0, bus.htrans}, 32'd2);
    check_eq("t6_haddr",  bus.haddr, 32'h0000_0050);
    tick(); settle();
    check_eq("t6_hwdata", bus.hwdata, 32'h0000_0077);
    check_eq("t6_no_old_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    tick(); settle();
    check_eq("t6_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_eq("t6_rsp_write", {31'd0, bus.rsp_write}, 32'd1);
    check_eq("t6_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
